// File: rtl/add8u_err_monitor_if.sv
// Sample/handshake/statistics bundle for the approximate-adder error monitor.
// The master drives stimulus and reads statistics; the slave is the monitor itself.
interface add8u_err_monitor_if #(
  parameter int unsigned WIN_LOG2 = 8
);
  logic                  start;
  logic                  in_valid;
  logic                  in_ready;
  logic [7:0]            a;
  logic [7:0]            b;
  logic [8:0]            o_apx;
  logic                  busy;
  logic                  done;
  logic [WIN_LOG2:0]     err_cnt;
  logic [8:0]            wce;
  logic [WIN_LOG2+8:0]   sae;

  modport master (
    output start, in_valid, a, b, o_apx,
    input  in_ready, busy, done, err_cnt, wce, sae
  );

  modport slave (
    input  start, in_valid, a, b, o_apx,
    output in_ready, busy, done, err_cnt, wce, sae
  );
endinterface

// File: rtl/add8u_err_monitor.sv
// Error-statistics monitor for an approximate 8-bit unsigned adder.
// Collects 2^WIN_LOG2 samples per window and reports error count, worst-case
// error and sum of absolute errors through a two-stage pipeline.
module add8u_err_monitor #(
  parameter int unsigned WIN_LOG2 = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  add8u_err_monitor_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
  typedef logic [WIN_LOG2:0]   cnt_t;
  typedef logic [WIN_LOG2+8:0] sae_t;

  localparam int unsigned WIN      = 1 << WIN_LOG2;
  localparam cnt_t        LAST_CNT = cnt_t'(WIN - 1);

  state_e     state_q, state_d;
  logic       in_ready_q, busy_q, done_q;
  cnt_t       cnt_q, cnt_d;

  logic       s1_v_q;
  logic [7:0] s1_a_q, s1_b_q;
  logic [8:0] s1_o_q;
  logic       s2_v_q;
  logic [8:0] s2_err_q, s2_err_d;

  cnt_t       err_cnt_q;
  logic [8:0] wce_q;
  sae_t       sae_q;

  logic       accept;
  logic       clear;
  logic [8:0] exact;

  assign accept = bus.in_valid & (state_q == RUN);
  assign clear  = bus.start & ((state_q == IDLE) | (state_q == DONE));

  // Next-state and sample counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d = cnt_q + cnt_t'(1);
    end
    unique case (state_q)
      IDLE, DONE: if (bus.start) state_d = RUN;
      RUN:        if (accept && (cnt_q == LAST_CNT)) state_d = DRAIN;
      // Stage 1 empty means stage 2 retires its last sample on this edge,
      // so the final statistic update and the DONE entry coincide.
      DRAIN:      if (!s1_v_q) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // FSM state with registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      in_ready_q <= (state_d == RUN);
      busy_q     <= (state_d == RUN) | (state_d == DRAIN);
      done_q     <= (state_d == DONE);
    end
  end

  // Stage 1: capture accepted sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q <= 1'b0;
      s1_a_q <= '0;
      s1_b_q <= '0;
      s1_o_q <= '0;
    end else begin
      s1_v_q <= accept;
      if (accept) begin
        s1_a_q <= bus.a;
        s1_b_q <= bus.b;
        s1_o_q <= bus.o_apx;
      end
    end
  end

  // Absolute error of the approximate sum against the exact 9-bit sum.
  always_comb begin
    exact    = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    s2_err_d = (s1_o_q >= exact) ? (s1_o_q - exact) : (exact - s1_o_q);
  end

  // Stage 2: hold the computed error for the statistics update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v_q   <= 1'b0;
      s2_err_q <= '0;
    end else begin
      s2_v_q <= s1_v_q;
      if (s1_v_q) s2_err_q <= s2_err_d;
    end
  end

  // Window statistics: cleared on window open, updated as stage 2 retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
      wce_q     <= '0;
      sae_q     <= '0;
    end else if (clear) begin
      err_cnt_q <= '0;
      wce_q     <= '0;
      sae_q     <= '0;
    end else if (s2_v_q) begin
      err_cnt_q <= err_cnt_q + cnt_t'(s2_err_q != '0);
      if (s2_err_q > wce_q) wce_q <= s2_err_q;
      sae_q     <= sae_q + sae_t'(s2_err_q);
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err_cnt  = err_cnt_q;
  assign bus.wce      = wce_q;
  assign bus.sae      = sae_q;

endmodule

// File: tb/tb_add8u_err_monitor.sv
// Bench for add8u_err_monitor: a 4-sample-window instance and a default
// 256-sample-window instance, checked every cycle against a window model.
module tb_add8u_err_monitor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  add8u_err_monitor_if #(.WIN_LOG2(2)) if2 ();
  add8u_err_monitor_if #(.WIN_LOG2(8)) if8 ();

  add8u_err_monitor #(.WIN_LOG2(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  add8u_err_monitor #(.WIN_LOG2(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

  // Stimulus drive arrays, index 0 -> 4-sample DUT, 1 -> 256-sample DUT.
  logic       d_start [2];
  logic       d_valid [2];
  logic [7:0] d_a     [2];
  logic [7:0] d_b     [2];
  logic [8:0] d_o     [2];

  assign if2.start = d_start[0]; assign if8.start = d_start[1];
  assign if2.in_valid = d_valid[0]; assign if8.in_valid = d_valid[1];
  assign if2.a = d_a[0]; assign if8.a = d_a[1];
  assign if2.b = d_b[0]; assign if8.b = d_b[1];
  assign if2.o_apx = d_o[0]; assign if8.o_apx = d_o[1];

  int rdy_w [2], busy_w [2], done_w [2], cnt_w [2], wce_w [2], sae_w [2];
  assign rdy_w[0] = int'(if2.in_ready); assign rdy_w[1] = int'(if8.in_ready);
  assign busy_w[0] = int'(if2.busy); assign busy_w[1] = int'(if8.busy);
  assign done_w[0] = int'(if2.done); assign done_w[1] = int'(if8.done);
  assign cnt_w[0] = int'(if2.err_cnt); assign cnt_w[1] = int'(if8.err_cnt);
  assign wce_w[0] = int'(if2.wce); assign wce_w[1] = int'(if8.wce);
  assign sae_w[0] = int'(if2.sae); assign sae_w[1] = int'(if8.sae);

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- window model ----------------
  // A window is the list of accepted samples; each sample's error counts in
  // the statistics from two edges after its acceptance onward.
  int m_win     [2] = '{4, 256};
  bit m_started [2] = '{0, 0};
  int m_nacc    [2] = '{0, 0};
  int m_last    [2] = '{0, 0};
  int m_err     [2][256];
  int m_due     [2][256];
  int cyc = 0;

  function automatic int abs_err(input int a, input int b, input int o);
    int e;
    e = o - (a + b);
    return (e < 0) ? -e : e;
  endfunction

  function automatic bit m_finished(input int d);
    return m_started[d] && (m_nacc[d] == m_win[d]) && (cyc >= m_last[d] + 2);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_started[d] <= 1'b0;
        m_nacc[d]    <= 0;
      end
    end else begin
      cyc <= cyc + 1;
      for (int d = 0; d < 2; d++) begin
        if (d_start[d] && !(m_started[d] && !m_finished(d))) begin
          m_started[d] <= 1'b1;
          m_nacc[d]    <= 0;
        end else if (m_started[d] && m_nacc[d] < m_win[d] && d_valid[d]) begin
          m_err[d][m_nacc[d]] <= abs_err(int'(d_a[d]), int'(d_b[d]), int'(d_o[d]));
          m_due[d][m_nacc[d]] <= cyc + 3;
          m_last[d]           <= cyc + 1;
          m_nacc[d]           <= m_nacc[d] + 1;
        end
      end
    end
  end

  // Per-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        int ec, ew, es;
        ec = 0; ew = 0; es = 0;
        for (int i = 0; i < m_nacc[d]; i++) begin
          if (m_due[d][i] <= cyc) begin
            if (m_err[d][i] != 0) ec++;
            if (m_err[d][i] > ew) ew = m_err[d][i];
            es += m_err[d][i];
          end
        end
        check($sformatf("d%0d_in_ready", d), rdy_w[d], int'(m_started[d] && m_nacc[d] < m_win[d]));
        check($sformatf("d%0d_busy", d), busy_w[d], int'(m_started[d] && !m_finished(d)));
        check($sformatf("d%0d_done", d), done_w[d], int'(m_finished(d)));
        check($sformatf("d%0d_err_cnt", d), cnt_w[d], ec);
        check($sformatf("d%0d_wce", d), wce_w[d], ew);
        check($sformatf("d%0d_sae", d), sae_w[d], es);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic put(input int d, input bit s, input bit v,
                     input int a, input int b, input int o);
    d_start[d] = s; d_valid[d] = v;
    d_a[d] = 8'(a); d_b[d] = 8'(b); d_o[d] = 9'(o);
    @(negedge clk); #1;
  endtask

  task automatic idle(input int d);
    d_start[d] = 1'b0; d_valid[d] = 1'b0;
    d_a[d] = '0; d_b[d] = '0; d_o[d] = '0;
  endtask

  task automatic wait_done(input int d, input int limit);
    int k;
    k = 0;
    while (done_w[d] == 0 && k < limit) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("d%0d_done_reached", d), done_w[d], 1);
  endtask

  task automatic lit(input string tag, input int c, input int w, input int s);
    check({tag, "_err_cnt"}, cnt_w[0], c);
    check({tag, "_wce"}, wce_w[0], w);
    check({tag, "_sae"}, sae_w[0], s);
  endtask

  initial begin
    idle(0); idle(1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    #1;
    check("reset_in_ready", rdy_w[0], 0);
    check("reset_busy", busy_w[0], 0);
    lit("reset", 0, 0, 0);

    // Exact sums: no error.
    put(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) put(0, 0, 1, 1, 1, 2);
    idle(0);
    wait_done(0, 10);
    lit("exact", 0, 0, 0);
    #1;

    // Errors +1, 0, -1, +3 starting from DONE.
    put(0, 1, 0, 0, 0, 0);
    put(0, 0, 1, 10, 5, 16);
    put(0, 0, 1, 10, 5, 15);
    put(0, 0, 1, 10, 5, 14);
    put(0, 0, 1, 10, 5, 18);
    idle(0);
    wait_done(0, 10);
    lit("mixed", 3, 3, 5);
    #1;

    // Worst case: 255+255 reported as 0.
    put(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) put(0, 0, 1, 255, 255, 0);
    idle(0);
    wait_done(0, 10);
    lit("extreme", 4, 510, 2040);
    #1;

    // Gapped valid with start pulsed during RUN and DRAIN; errors 1..4.
    put(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      put(0, (i % 2) == 1, (i % 2) == 0, 3, 4, 7 + i / 2 + 1);
    d_start[0] = 1'b0; d_valid[0] = 1'b1; d_a[0] = 8'd0; d_b[0] = 8'd0; d_o[0] = 9'd100;
    wait_done(0, 10);
    lit("gapped", 4, 4, 10);
    repeat (3) @(negedge clk);
    check("gapped_hold_done", done_w[0], 1);
    lit("gapped_hold", 4, 4, 10);
    #1;

    // Reset mid-window after two samples.
    put(0, 1, 0, 0, 0, 0);
    put(0, 0, 1, 1, 2, 9);
    put(0, 0, 1, 1, 2, 9);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_in_ready", rdy_w[0], 0);
    check("rst_busy", busy_w[0], 0);
    check("rst_done", done_w[0], 0);
    lit("rst", 0, 0, 0);
    #1;
    rst_n = 1'b1;
    put(0, 0, 1, 1, 2, 9);
    put(0, 0, 1, 1, 2, 9);
    check("post_rst_idle_busy", busy_w[0], 0);
    put(0, 1, 0, 0, 0, 0);
    put(0, 0, 1, 20, 30, 50);
    put(0, 0, 1, 20, 30, 55);
    put(0, 0, 1, 20, 30, 50);
    put(0, 0, 1, 20, 30, 48);
    idle(0);
    wait_done(0, 10);
    lit("after_rst", 2, 5, 7);
    #1;

    // Default window: 256 random samples with random gaps.
    put(1, 1, 0, 0, 0, 0);
    for (int k = 0; k < 2000 && m_nacc[1] < 256; k++) begin
      int a, b, o, mode;
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      mode = int'($urandom_range(0, 3));
      case (mode)
        0: o = a + b;
        1: o = (a + b + int'($urandom_range(0, 7))) % 512;
        2: o = (a + b >= 7) ? a + b - int'($urandom_range(0, 7)) : 0;
        default: o = int'($urandom_range(0, 511));
      endcase
      put(1, 0, $urandom_range(0, 3) != 0, a, b, o);
    end
    idle(1);
    wait_done(1, 10);
    check("rand_in_ready_done", rdy_w[1], 0);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d expected=%0d", 1, 0);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
